wh_output_alloc: RTL

//   Wormhole output-port allocator for one router output. Shares the output link between
//   N input ports using round-robin arbitration. A grant is locked from a packet's head

---
 rtl/noc_pkg.sv | 22 ++
 rtl/rr_pick.sv | 31 +++
 rtl/wh_output_alloc.sv | 110 +++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC router slice: allocator state encoding,
// flit-type bit positions and a constant-foldable clog2.
package noc_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int unsigned HEAD = 0;
  localparam int unsigned TAIL = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N, found by priority-encoding a doubled request vector.
module rr_pick
  import noc_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned SW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [2*N-1:0] dbl;

  assign dbl = {req, req};

  // Window (ptr, ptr+N] over the doubled vector covers each input exactly once.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned j = 0; j < 2 * N; j++) begin
      if (!found && dbl[j] && (j > 32'(ptr)) && (j <= 32'(ptr) + N)) begin
        found = 1'b1;
        idx   = SW'((j >= N) ? (j - N) : j);
      end
    end
  end

endmodule

// File: rtl/wh_output_alloc.sv
// Wormhole output-port allocator: round-robin head arbitration, grant locked
// from head to tail, sends gated by a downstream credit counter.
module wh_output_alloc
  import noc_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = clog2(DEPTH + 1),
  localparam int unsigned SW    = clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in_valid,
  input  logic [N-1:0]  in_head,
  input  logic [N-1:0]  in_tail,
  input  logic          credit_in,
  output logic [N-1:0]  in_ready,
  output logic          out_valid,
  output logic [SW-1:0] out_sel,
  output logic [CW-1:0] credits,
  output logic          busy,
  output logic          cred_err
);

  state_e        state_q;
  logic [SW-1:0] owner_q;
  logic [SW-1:0] ptr_q;
  logic [CW-1:0] credits_q, credits_d;
  logic          cred_err_q, cred_err_d;

  logic          can_send;
  logic          found;
  logic          send;
  logic [SW-1:0] pick;
  logic [SW-1:0] sel;
  logic [N-1:0]  cand;
  logic [N-1:0]  grant;

  assign cand = in_valid & in_head;

  rr_pick #(.N(N)) u_pick (
    .req   (cand),
    .ptr   (ptr_q),
    .found (found),
    .idx   (pick)
  );

  always_comb begin
    can_send = (credits_q != '0);
    grant    = '0;
    sel      = '0;
    if (state_q == ST_IDLE) begin
      if (found && can_send) begin
        grant[pick] = 1'b1;
        sel         = pick;
      end
    end else begin
      sel = owner_q;
      if (in_valid[owner_q] && can_send) grant[owner_q] = 1'b1;
    end
  end

  assign send = |grant;

  // Credit update; a return at full count is clamped and flagged instead of wrapping.
  always_comb begin
    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    if (send && !credit_in) begin
      credits_d = credits_q - CW'(1);
    end else if (!send && credit_in) begin
      if (credits_q == CW'(DEPTH)) cred_err_d = 1'b1;
      else                         credits_d  = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      ptr_q      <= SW'(N - 1);
      credits_q  <= CW'(DEPTH);
      cred_err_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      cred_err_q <= cred_err_d;
      if (send) begin
        if (state_q == ST_IDLE) begin
          if (in_tail[pick]) begin
            ptr_q <= pick;
          end else begin
            state_q <= ST_LOCKED;
            owner_q <= pick;
          end
        end else if (in_tail[owner_q]) begin
          state_q <= ST_IDLE;
          ptr_q   <= owner_q;
        end
      end
    end
  end

  assign in_ready  = reset ? grant : '0;
  assign out_valid = |in_ready;
  assign out_sel   = reset ? sel : '0;
  assign busy      = reset && (state_q == ST_LOCKED);
  assign credits   = credits_q;
  assign cred_err  = cred_err_q;

endmodule
